// File: rtl/ctl_pkg.sv
// Shared types and constants for the rv32 decode control stage: opcodes, ALU codes,
// selector enums and the registered control bundle.
package ctl_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  localparam logic [6:0] Funct7Mext = 7'b0000001;

  localparam logic [4:0] AluAnd   = 5'b00000;
  localparam logic [4:0] AluOr    = 5'b00001;
  localparam logic [4:0] AluAdd   = 5'b00010;
  localparam logic [4:0] AluXor   = 5'b00011;
  localparam logic [4:0] AluSll   = 5'b00100;
  localparam logic [4:0] AluSrl   = 5'b00101;
  localparam logic [4:0] AluSub   = 5'b00110;
  localparam logic [4:0] AluSra   = 5'b00111;
  localparam logic [4:0] AluSlt   = 5'b01000;
  localparam logic [4:0] AluPassB = 5'b01001;
  localparam logic [4:0] AluSltu  = 5'b01010;
  // MUL..REMU occupy 10000..10111, indexed by funct3.
  localparam logic [4:0] AluMul   = 5'b10000;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5
  } imm_sel_e;

  typedef enum logic [1:0] {
    PcPlus4  = 2'd0,
    PcBranch = 2'd1,
    PcJump   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WbMem = 2'd0,
    WbAlu = 2'd1,
    WbPc4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic       a_sel;
    logic       b_sel;
    logic [4:0] alu_sel;
    logic       mem_wr;
    logic       mem_rd;
    logic       reg_wen;
    imm_sel_e   imm_sel;
    logic       br_un;
    pc_sel_e    pc_sel;
    wb_sel_e    wb_sel;
    logic       illegal;
  } ctl_bundle_t;

  // funct7[5] selects SUB only for register-register ops; SRA/SRAI use it in both forms.
  function automatic logic [4:0] alu_from_funct(input logic [2:0] funct3, input logic f7b5,
                                                input logic is_op);
    logic [4:0] code;
    case (funct3)
      3'b000:  code = (is_op && f7b5) ? AluSub : AluAdd;
      3'b001:  code = AluSll;
      3'b010:  code = AluSlt;
      3'b011:  code = AluSltu;
      3'b100:  code = AluXor;
      3'b101:  code = f7b5 ? AluSra : AluSrl;
      3'b110:  code = AluOr;
      default: code = AluAnd;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctl_decode_stage_if.sv
// Fetch-side and execute-side handshake plus control bundle of the decode stage.
interface ctl_decode_stage_if #(
  parameter int unsigned ALU_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [31:0]          in_pc;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_pc;
  logic [31:0]          out_instr;
  logic                 a_sel;
  logic                 b_sel;
  logic [ALU_W-1:0]     alu_sel;
  logic                 mem_wr;
  logic                 mem_rd;
  logic                 reg_wen;
  ctl_pkg::imm_sel_e    imm_sel;
  logic                 br_un;
  ctl_pkg::pc_sel_e     pc_sel;
  ctl_pkg::wb_sel_e     wb_sel;
  logic                 illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, a_sel, b_sel, alu_sel, mem_wr, mem_rd,
           reg_wen, imm_sel, br_un, pc_sel, wb_sel, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, a_sel, b_sel, alu_sel, mem_wr, mem_rd,
           reg_wen, imm_sel, br_un, pc_sel, wb_sel, illegal
  );
endinterface

// File: rtl/ctl_decode_comb.sv
// Pure combinational RV32I(+M) instruction to execute-control bundle decoder.
module ctl_decode_comb
  import ctl_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0] i_instr,
  output ctl_bundle_t o_bundle
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_ill;
  ctl_bundle_t w_bundle;
  logic        w_unused;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_unused = ^i_instr[24:15];

  always_comb begin
    w_bundle = '0;
    w_ill    = 1'b0;
    case (w_opcode)
      OpcLui: begin
        w_bundle.b_sel = 1'b1; w_bundle.alu_sel = AluPassB; w_bundle.imm_sel = ImmU;
        w_bundle.wb_sel = WbAlu; w_bundle.reg_wen = 1'b1;
      end
      OpcAuipc: begin
        w_bundle.a_sel = 1'b1; w_bundle.b_sel = 1'b1; w_bundle.alu_sel = AluAdd;
        w_bundle.imm_sel = ImmU; w_bundle.wb_sel = WbAlu; w_bundle.reg_wen = 1'b1;
      end
      OpcJal: begin
        w_bundle.a_sel = 1'b1; w_bundle.b_sel = 1'b1; w_bundle.alu_sel = AluAdd;
        w_bundle.imm_sel = ImmJ; w_bundle.pc_sel = PcJump; w_bundle.wb_sel = WbPc4;
        w_bundle.reg_wen = 1'b1;
      end
      OpcJalr: begin
        w_bundle.b_sel = 1'b1; w_bundle.alu_sel = AluAdd; w_bundle.imm_sel = ImmI;
        w_bundle.pc_sel = PcJump; w_bundle.wb_sel = WbPc4; w_bundle.reg_wen = 1'b1;
      end
      OpcBranch: begin
        w_bundle.a_sel = 1'b1; w_bundle.b_sel = 1'b1; w_bundle.alu_sel = AluAdd;
        w_bundle.imm_sel = ImmB; w_bundle.pc_sel = PcBranch; w_bundle.br_un = w_funct3[1];
        w_ill = (w_funct3[2:1] == 2'b01);
      end
      OpcLoad: begin
        w_bundle.b_sel = 1'b1; w_bundle.alu_sel = AluAdd; w_bundle.imm_sel = ImmI;
        w_bundle.mem_rd = 1'b1; w_bundle.wb_sel = WbMem; w_bundle.reg_wen = 1'b1;
      end
      OpcStore: begin
        w_bundle.b_sel = 1'b1; w_bundle.alu_sel = AluAdd; w_bundle.imm_sel = ImmS;
        w_bundle.mem_wr = 1'b1;
      end
      OpcOpImm: begin
        w_bundle.b_sel = 1'b1; w_bundle.imm_sel = ImmI; w_bundle.wb_sel = WbAlu;
        w_bundle.reg_wen = 1'b1;
        w_bundle.alu_sel = alu_from_funct(w_funct3, w_funct7[5], 1'b0);
      end
      OpcOp: begin
        w_bundle.wb_sel = WbAlu; w_bundle.reg_wen = 1'b1;
        if (w_funct7 == Funct7Mext) begin
          w_bundle.alu_sel = AluMul | {2'b00, w_funct3};
          w_ill = !M_EXT;
        end else begin
          w_bundle.alu_sel = alu_from_funct(w_funct3, w_funct7[5], 1'b1);
        end
      end
      default: w_ill = 1'b1;
    endcase
    if (w_rd == 5'd0) w_bundle.reg_wen = 1'b0;
    // Illegal bundles carry no side effects downstream.
    if (w_ill) begin
      w_bundle         = '0;
      w_bundle.illegal = 1'b1;
    end
  end

  assign o_bundle = w_bundle;

endmodule

// File: rtl/ctl_decode_stage.sv
// Registered decode stage: valid/ready on both sides, flush, and load-use bubble insertion.
module ctl_decode_stage
  import ctl_pkg::*;
#(
  parameter bit          M_EXT     = 1'b0,
  parameter bit          HAZARD_EN = 1'b1,
  parameter int unsigned ALU_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  ctl_decode_stage_if.slave   bus
);

  ctl_bundle_t w_dec;
  ctl_bundle_t r_bundle;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  logic [6:0]  w_in_opc;
  logic [4:0]  w_rd_held;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_hazard;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_out_fire;

  ctl_decode_comb #(
    .M_EXT (M_EXT)
  ) u_decode (
    .i_instr  (bus.in_instr),
    .o_bundle (w_dec)
  );

  assign w_in_opc   = bus.in_instr[6:0];
  assign w_rd_held  = r_instr[11:7];
  assign w_uses_rs1 = !(w_in_opc inside {OpcLui, OpcAuipc, OpcJal});
  assign w_uses_rs2 = w_in_opc inside {OpcOp, OpcStore, OpcBranch};

  // A dependent instruction waits one cycle behind a held load so it never sees stale data.
  assign w_hazard = HAZARD_EN && r_valid && r_bundle.mem_rd && (w_rd_held != 5'd0) &&
                    bus.in_valid &&
                    ((w_uses_rs1 && (bus.in_instr[19:15] == w_rd_held)) ||
                     (w_uses_rs2 && (bus.in_instr[24:20] == w_rd_held)));

  assign w_in_ready = (!r_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_fire = r_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
      r_pc     <= '0;
      r_instr  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_bundle <= w_dec;
      r_pc     <= bus.in_pc;
      r_instr  <= bus.in_instr;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_pc    = r_pc;
  assign bus.out_instr = r_instr;
  assign bus.a_sel     = r_bundle.a_sel;
  assign bus.b_sel     = r_bundle.b_sel;
  assign bus.alu_sel   = ALU_W'(r_bundle.alu_sel);
  assign bus.mem_wr    = r_bundle.mem_wr;
  assign bus.mem_rd    = r_bundle.mem_rd;
  assign bus.reg_wen   = r_bundle.reg_wen;
  assign bus.imm_sel   = r_bundle.imm_sel;
  assign bus.br_un     = r_bundle.br_un;
  assign bus.pc_sel    = r_bundle.pc_sel;
  assign bus.wb_sel    = r_bundle.wb_sel;
  assign bus.illegal   = r_bundle.illegal;

endmodule

// File: tb/tb_ctl_decode_stage.sv
// Scoreboard bench: M_EXT=1 and M_EXT=0 stages driven in lockstep, each with its own queue.
module tb_ctl_decode_stage;
  import ctl_pkg::*;

  typedef logic [82:0] exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctl_decode_stage_if #(.ALU_W(5)) bus1 ();
  ctl_decode_stage_if #(.ALU_W(5)) bus0 ();

  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.in_instr  = bus1.in_instr;
  assign bus0.in_pc     = bus1.in_pc;
  assign bus0.flush     = bus1.flush;
  assign bus0.out_ready = bus1.out_ready;

  ctl_decode_stage #(.M_EXT(1'b1), .HAZARD_EN(1'b1), .ALU_W(5)) u_dut_m1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  ctl_decode_stage #(.M_EXT(1'b0), .HAZARD_EN(1'b1), .ALU_W(5)) u_dut_m0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  exp_t q1[$];
  exp_t q0[$];
  int   checks = 0;
  int   errors = 0;
  exp_t act1, act0, exp1, exp0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic a,
                              input logic b, input logic [4:0] alu, input logic mw,
                              input logic mr, input logic wen, input logic [2:0] imm,
                              input logic bu, input logic [1:0] pcs, input logic [1:0] wb,
                              input logic ill);
    return {pc, instr, a, b, alu, mw, mr, wen, imm, bu, pcs, wb, ill};
  endfunction

  function automatic exp_t mk_ill(input logic [31:0] pc, input logic [31:0] instr);
    return mk(pc, instr, 0, 0, 5'd0, 0, 0, 0, 3'd0, 0, 2'd0, 2'd0, 1);
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      act1 = {bus1.out_pc, bus1.out_instr, bus1.a_sel, bus1.b_sel, bus1.alu_sel, bus1.mem_wr,
              bus1.mem_rd, bus1.reg_wen, bus1.imm_sel, bus1.br_un, bus1.pc_sel, bus1.wb_sel,
              bus1.illegal};
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL m1_unexpected act=%h req=<empty queue>", act1);
      end else begin
        exp1 = q1.pop_front();
        if (act1 !== exp1) begin
          errors++;
          $display("FAIL m1_bundle pc=%h act=%h req=%h", exp1[82:51], act1, exp1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      act0 = {bus0.out_pc, bus0.out_instr, bus0.a_sel, bus0.b_sel, bus0.alu_sel, bus0.mem_wr,
              bus0.mem_rd, bus0.reg_wen, bus0.imm_sel, bus0.br_un, bus0.pc_sel, bus0.wb_sel,
              bus0.illegal};
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL m0_unexpected act=%h req=<empty queue>", act0);
      end else begin
        exp0 = q0.pop_front();
        if (act0 !== exp0) begin
          errors++;
          $display("FAIL m0_bundle pc=%h act=%h req=%h", exp0[82:51], act0, exp0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Offer one instruction; push expectations on the cycle it is accepted.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e1,
                      input exp_t e0, output int waits, output logic ov_at_acc);
    logic ok;
    ok = 1'b0;
    waits = 0;
    ov_at_acc = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_instr = instr;
    bus1.in_pc    = pc;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus1.in_ready) begin
        q1.push_back(e1);
        q0.push_back(e0);
        ov_at_acc = bus1.out_valid;
        ok = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=in_ready stuck 0 req=accept of %h", instr);
    end
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int   w;
  logic ov;
  exp_t e;

  initial begin
    bus1.in_valid  = 1'b0;
    bus1.in_instr  = '0;
    bus1.in_pc     = '0;
    bus1.flush     = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_out_pc", bus1.out_pc, 32'd0);
    chk("rst_out_instr", bus1.out_instr, 32'd0);
    chk("rst_alu_sel", 32'(bus1.alu_sel), 32'd0);
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("rst_m0_out_valid", 32'(bus0.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // LUI x1, 0x12345
    e = mk(32'h100, 32'h123450B7, 0, 1, AluPassB, 0, 0, 1, 3'd4, 0, 2'd0, 2'd1, 0);
    send(32'h123450B7, 32'h100, e, e, w, ov);
    chk("lui_no_wait", 32'(w), 32'd0);
    idle(2);

    // LW x5,0(x1) then dependent ADD x6,x5,x1
    e = mk(32'h104, 32'h0000A283, 0, 1, AluAdd, 0, 1, 1, 3'd1, 0, 2'd0, 2'd0, 0);
    send(32'h0000A283, 32'h104, e, e, w, ov);
    e = mk(32'h108, 32'h00128333, 0, 0, AluAdd, 0, 0, 1, 3'd0, 0, 2'd0, 2'd1, 0);
    send(32'h00128333, 32'h108, e, e, w, ov);
    chk("hazard_stall_cycles", 32'(w), 32'd1);
    chk("hazard_bubble", 32'(ov), 32'd0);
    idle(2);

    // JAL x1,+8 held with out_ready low for 3 cycles, ADDI x1,x0,5 waiting behind it
    bus1.out_ready = 1'b0;
    e = mk(32'h10C, 32'h008000EF, 1, 1, AluAdd, 0, 0, 1, 3'd5, 0, 2'd2, 2'd2, 0);
    send(32'h008000EF, 32'h10C, e, e, w, ov);
    bus1.in_valid = 1'b1;
    bus1.in_instr = 32'h00500093;
    bus1.in_pc    = 32'h110;
    repeat (3) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(bus1.out_valid), 32'd1);
      chk("hold_out_instr", bus1.out_instr, 32'h008000EF);
      chk("hold_pc_sel", 32'(bus1.pc_sel), 32'd2);
      chk("hold_wb_sel", 32'(bus1.wb_sel), 32'd2);
      chk("hold_in_ready", 32'(bus1.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus1.out_ready = 1'b1;
    @(negedge clk);
    chk("accept_on_ready_rise", 32'(bus1.in_ready), 32'd1);
    if (bus1.in_ready) begin
      e = mk(32'h110, 32'h00500093, 0, 1, AluAdd, 0, 0, 1, 3'd1, 0, 2'd0, 2'd1, 0);
      q1.push_back(e);
      q0.push_back(e);
    end
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    idle(2);

    // Flush kills held SUB x3,x1,x2 and the offered SW
    bus1.out_ready = 1'b0;
    e = mk(32'h114, 32'h402081B3, 0, 0, AluSub, 0, 0, 1, 3'd0, 0, 2'd0, 2'd1, 0);
    send(32'h402081B3, 32'h114, e, e, w, ov);
    bus1.in_valid = 1'b1;
    bus1.in_instr = 32'h0020A223;
    bus1.in_pc    = 32'h118;
    bus1.flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus1.in_ready), 32'd0);
    chk("flush_held_valid", 32'(bus1.out_valid), 32'd1);
    @(posedge clk);
    #1;
    bus1.flush    = 1'b0;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("flush_m0_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("flush_no_capture", bus1.out_instr, 32'h402081B3);
    void'(q1.pop_back());
    void'(q0.pop_back());
    @(posedge clk);
    #1 bus1.out_ready = 1'b1;

    // Streamed decode vectors
    e = mk(32'h118, 32'h0020A223, 0, 1, AluAdd, 1, 0, 0, 3'd2, 0, 2'd0, 2'd0, 0);
    send(32'h0020A223, 32'h118, e, e, w, ov);
    e = mk(32'h11C, 32'h40325213, 0, 1, AluSra, 0, 0, 1, 3'd1, 0, 2'd0, 2'd1, 0);
    send(32'h40325213, 32'h11C, e, e, w, ov);
    e = mk(32'h120, 32'h0020E463, 1, 1, AluAdd, 0, 0, 0, 3'd3, 1, 2'd1, 2'd0, 0);
    send(32'h0020E463, 32'h120, e, e, w, ov);
    e = mk(32'h124, 32'h00000013, 0, 1, AluAdd, 0, 0, 0, 3'd1, 0, 2'd0, 2'd1, 0);
    send(32'h00000013, 32'h124, e, e, w, ov);
    send(32'h0000007F, 32'h128, mk_ill(32'h128, 32'h0000007F), mk_ill(32'h128, 32'h0000007F),
         w, ov);
    send(32'h00002063, 32'h12C, mk_ill(32'h12C, 32'h00002063), mk_ill(32'h12C, 32'h00002063),
         w, ov);
    e = mk(32'h130, 32'h02208033, 0, 0, AluMul, 0, 0, 0, 3'd0, 0, 2'd0, 2'd1, 0);
    send(32'h02208033, 32'h130, e, mk_ill(32'h130, 32'h02208033), w, ov);
    e = mk(32'h134, 32'h022081B3, 0, 0, AluMul, 0, 0, 1, 3'd0, 0, 2'd0, 2'd1, 0);
    send(32'h022081B3, 32'h134, e, mk_ill(32'h134, 32'h022081B3), w, ov);
    e = mk(32'h138, 32'h0220D1B3, 0, 0, 5'b10101, 0, 0, 1, 3'd0, 0, 2'd0, 2'd1, 0);
    send(32'h0220D1B3, 32'h138, e, mk_ill(32'h138, 32'h0220D1B3), w, ov);
    idle(5);

    chk("m1_queue_drained", 32'(q1.size()), 32'd0);
    chk("m0_queue_drained", 32'(q0.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout act=still running req=finished");
    $fatal(1, "timeout");
  end

endmodule
